// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types and response codes.
// Used by both the single-beat master and the register bank slave.
package axi_lite_pkg;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_EXOKAY = 2'b01;
    localparam axi_resp_t RESP_SLVERR = 2'b10;
    localparam axi_resp_t RESP_DECERR = 2'b11;

    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

endpackage

// File: rtl/axi_lite_reg_array.sv
// Register storage with byte-strobe write port and asynchronous read.
// Entry 0 is never stored; it always reflects the hardware status word.
module axi_lite_reg_array
    import axi_lite_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int IDXW     = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_we,
    input  logic [IDXW-1:0]                i_widx,
    input  logic [AXI_DATA_W-1:0]          i_wdata,
    input  logic [AXI_STRB_W-1:0]          i_wstrb,
    input  logic [IDXW-1:0]                i_ridx,
    input  logic [AXI_DATA_W-1:0]          i_status,
    output logic [AXI_DATA_W-1:0]          o_rdata,
    output logic [NUM_REGS*AXI_DATA_W-1:0] o_regs
);

    logic [AXI_DATA_W-1:0] r_mem [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_mem[k] <= '0;
            end
        end else if (i_we && (i_widx != '0)) begin
            for (int b = 0; b < AXI_STRB_W; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = (i_ridx == '0) ? i_status : r_mem[i_ridx];

    always_comb begin
        o_regs = '0;
        o_regs[AXI_DATA_W-1:0] = i_status;
        for (int k = 1; k < NUM_REGS; k++) begin
            o_regs[k*AXI_DATA_W +: AXI_DATA_W] = r_mem[k];
        end
    end

endmodule

// File: rtl/axi_lite_slave_regbank.sv
// AXI4-Lite slave terminating AW/W/B and AR/R against a register array.
// Register 0 is read-only hardware status; the rest are R/W control.
module axi_lite_slave_regbank
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [3:0]                     S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    input  logic [DATA_WIDTH-1:0]          status_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    localparam int IDXW = $clog2(NUM_REGS);

    logic            r_bvalid;
    axi_resp_t       r_bresp;
    logic            r_rvalid;
    axi_resp_t       r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic            w_aw_hs;
    logic            w_ar_hs;
    logic            w_wr_inrng;
    logic            w_rd_inrng;
    logic [IDXW-1:0] w_widx;
    logic [IDXW-1:0] w_ridx;
    logic            w_wr_ok;
    logic [DATA_WIDTH-1:0] w_arr_rdata;

    assign w_widx     = S_AXI_AWADDR[IDXW+1:2];
    assign w_ridx     = S_AXI_ARADDR[IDXW+1:2];
    assign w_wr_inrng = (S_AXI_AWADDR >> (IDXW + 2)) == '0;
    assign w_rd_inrng = (S_AXI_ARADDR >> (IDXW + 2)) == '0;
    assign w_wr_ok    = w_wr_inrng && (w_widx != '0);

    // AW and W are only ever accepted together, one write in flight.
    assign w_aw_hs = S_AXI_AWVALID & S_AXI_WVALID & ~r_bvalid;
    assign w_ar_hs = S_AXI_ARVALID & ~r_rvalid;

    assign S_AXI_AWREADY = w_aw_hs;
    assign S_AXI_WREADY  = w_aw_hs;
    assign S_AXI_ARREADY = ~r_rvalid;

    axi_lite_reg_array #(
        .NUM_REGS (NUM_REGS),
        .IDXW     (IDXW)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_aw_hs & w_wr_ok),
        .i_widx   (w_widx),
        .i_wdata  (S_AXI_WDATA),
        .i_wstrb  (S_AXI_WSTRB),
        .i_ridx   (w_ridx),
        .i_status (status_i),
        .o_rdata  (w_arr_rdata),
        .o_regs   (regs_o)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else if (w_aw_hs) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
        end
    end

    // Array read is taken before any same-edge write lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rresp  <= RESP_OKAY;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_rd_inrng ? RESP_OKAY : RESP_SLVERR;
            r_rdata  <= w_rd_inrng ? w_arr_rdata : '0;
        end else if (S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    assign S_AXI_BVALID = r_bvalid;
    assign S_AXI_BRESP  = r_bresp;
    assign S_AXI_RVALID = r_rvalid;
    assign S_AXI_RRESP  = r_rresp;
    assign S_AXI_RDATA  = r_rdata;

endmodule

// File: tb/tb_axi_lite_slave_regbank.sv
// Scoreboard bench for the AXI4-Lite register bank.
// Drivers push expected B/R responses; a monitor pops them on handshakes.
module tb_axi_lite_slave_regbank;
    import axi_lite_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam logic [31:0] STATUS = 32'hA5A5A5A5;

    logic          clk;
    logic          rst;
    logic [AW-1:0] S_AXI_AWADDR;
    logic          S_AXI_AWVALID;
    logic          S_AXI_AWREADY;
    logic [DW-1:0] S_AXI_WDATA;
    logic [3:0]    S_AXI_WSTRB;
    logic          S_AXI_WVALID;
    logic          S_AXI_WREADY;
    logic [1:0]    S_AXI_BRESP;
    logic          S_AXI_BVALID;
    logic          S_AXI_BREADY;
    logic [AW-1:0] S_AXI_ARADDR;
    logic          S_AXI_ARVALID;
    logic          S_AXI_ARREADY;
    logic [DW-1:0] S_AXI_RDATA;
    logic [1:0]    S_AXI_RRESP;
    logic          S_AXI_RVALID;
    logic          S_AXI_RREADY;
    logic [DW-1:0] status_i;
    logic [NR*DW-1:0] regs_o;

    axi_lite_slave_regbank #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .status_i      (status_i),
        .regs_o        (regs_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } rexp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [1:0]  bq[$];
    rexp_t       rq[$];
    logic [31:0] m_reg [NR];
    int          b_mode = 1;
    int          r_mode = 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected expected handshake", name);
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return a < 32'(NR * 4);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a % 32'(NR * 4)) / 32'd4);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s);
        logic [31:0] mask;
        mask = '0;
        for (int b = 0; b < 4; b++)
            if (s[b]) mask = mask | (32'hFF << (8 * b));
        if (in_rng(a) && idx_of(a) != 0) begin
            m_reg[idx_of(a)] = (m_reg[idx_of(a)] & ~mask) | (d & mask);
            bq.push_back(RESP_OKAY);
        end else begin
            bq.push_back(RESP_SLVERR);
        end
    endtask

    task automatic model_read(input logic [31:0] a);
        rexp_t e;
        if (!in_rng(a)) begin
            e.resp = RESP_SLVERR;
            e.data = '0;
        end else if (idx_of(a) == 0) begin
            e.resp = RESP_OKAY;
            e.data = status_i;
        end else begin
            e.resp = RESP_OKAY;
            e.data = m_reg[idx_of(a)];
        end
        rq.push_back(e);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        bit ok;
        ok = 0;
        S_AXI_AWADDR  = a;
        S_AXI_WDATA   = d;
        S_AXI_WSTRB   = s;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (S_AXI_AWREADY && S_AXI_WREADY) begin
                ok = 1;
                model_write(a, d, s);
            end
            @(posedge clk);
            #1;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        if (!ok) fail_now("write_timeout");
    endtask

    task automatic do_read(input logic [31:0] a);
        bit ok;
        ok = 0;
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (S_AXI_ARREADY) begin
                ok = 1;
                model_read(a);
            end
            @(posedge clk);
            #1;
        end
        S_AXI_ARVALID = 1'b0;
        if (!ok) fail_now("read_timeout");
    endtask

    // Read and write raised together once both channels are idle.
    task automatic do_both(input logic [31:0] ra, input logic [31:0] wa,
                           input logic [31:0] d, input logic [3:0] s);
        bit idle;
        idle = 0;
        for (int i = 0; i < 60 && !idle; i++) begin
            @(negedge clk);
            idle = !S_AXI_BVALID && !S_AXI_RVALID;
            @(posedge clk);
            #1;
        end
        if (!idle) begin
            fail_now("both_idle_timeout");
            return;
        end
        S_AXI_ARADDR  = ra;
        S_AXI_AWADDR  = wa;
        S_AXI_WDATA   = d;
        S_AXI_WSTRB   = s;
        S_AXI_ARVALID = 1'b1;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        @(negedge clk);
        check("both_ready",
              {29'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY},
              32'h7);
        model_read(ra);
        model_write(wa, d, s);
        @(posedge clk);
        #1;
        S_AXI_ARVALID = 1'b0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
    endtask

    task automatic check_image(input string name);
        check({name, "_r0"}, regs_o[31:0], status_i);
        for (int k = 1; k < NR; k++)
            check(name, regs_o[k*32 +: 32], m_reg[k]);
    endtask

    initial begin
        S_AXI_BREADY = 1'b0;
        S_AXI_RREADY = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            S_AXI_BREADY = (b_mode == 2) ? 1'($urandom_range(0, 1))
                                          : (b_mode == 1);
            S_AXI_RREADY = (r_mode == 2) ? 1'($urandom_range(0, 1))
                                          : (r_mode == 1);
        end
    end

    logic        b_hold = 1'b0;
    logic [1:0]  b_prev;
    logic        r_hold = 1'b0;
    logic [1:0]  r_prev;
    logic [31:0] rd_prev;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                b_hold = 1'b0;
                r_hold = 1'b0;
            end else begin
                if (S_AXI_BVALID) begin
                    if (b_hold) check("b_stable", 32'(S_AXI_BRESP), 32'(b_prev));
                    if (S_AXI_BREADY) begin
                        if (bq.size() == 0) begin
                            fail_now("b_unexpected");
                        end else begin
                            logic [1:0] e;
                            e = bq.pop_front();
                            check("bresp", 32'(S_AXI_BRESP), 32'(e));
                        end
                        b_hold = 1'b0;
                    end else begin
                        b_hold = 1'b1;
                        b_prev = S_AXI_BRESP;
                    end
                end else begin
                    b_hold = 1'b0;
                end
                if (S_AXI_RVALID) begin
                    if (r_hold) begin
                        check("r_stable_resp", 32'(S_AXI_RRESP), 32'(r_prev));
                        check("r_stable_data", S_AXI_RDATA, rd_prev);
                    end
                    if (S_AXI_RREADY) begin
                        if (rq.size() == 0) begin
                            fail_now("r_unexpected");
                        end else begin
                            rexp_t e;
                            e = rq.pop_front();
                            check("rresp", 32'(S_AXI_RRESP), 32'(e.resp));
                            check("rdata", S_AXI_RDATA, e.data);
                        end
                        r_hold = 1'b0;
                    end else begin
                        r_hold  = 1'b1;
                        r_prev  = S_AXI_RRESP;
                        rd_prev = S_AXI_RDATA;
                    end
                end else begin
                    r_hold = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        status_i      = STATUS;
        S_AXI_AWADDR  = '0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = '0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARADDR  = '0;
        S_AXI_ARVALID = 1'b0;
        for (int k = 0; k < NR; k++) m_reg[k] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
        check("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
        check("rst_bresp", 32'(S_AXI_BRESP), 32'd0);
        check("rst_rdata", S_AXI_RDATA, 32'd0);
        check_image("rst_image");
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_write(32'h04, 32'hDEADBEEF, 4'hF);
        check("w1_bvalid", 32'(S_AXI_BVALID), 32'd1);
        check("w1_regs", regs_o[63:32], 32'hDEADBEEF);
        do_read(32'h04);
        check("r1_rvalid", 32'(S_AXI_RVALID), 32'd1);

        do_write(32'h04, 32'h11223344, 4'b0101);
        check("strb_regs", regs_o[63:32], 32'hDE22BE44);
        do_read(32'h04);

        do_write(32'h40, 32'h12345678, 4'hF);
        check_image("oor_write");
        do_write(32'h00, 32'hFFFFFFFF, 4'hF);
        do_read(32'h00);
        do_read(32'h80);
        do_write(32'h0B, 32'h55555555, 4'h0);
        check("strb0_regs", regs_o[95:64], 32'd0);

        b_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        do_write(32'h08, 32'h1, 4'hF);
        S_AXI_AWADDR  = 32'h0C;
        S_AXI_WDATA   = 32'h77;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_awready", 32'(S_AXI_AWREADY), 32'd0);
            check("bp_wready", 32'(S_AXI_WREADY), 32'd0);
            check("bp_bvalid", 32'(S_AXI_BVALID), 32'd1);
            @(posedge clk);
            #1;
        end
        b_mode = 1;
        do_write(32'h0C, 32'h77, 4'hF);
        check("bp_regs", regs_o[127:96], 32'h77);

        r_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        do_read(32'h0C);
        S_AXI_ARADDR  = 32'h04;
        S_AXI_ARVALID = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("rbp_arready", 32'(S_AXI_ARREADY), 32'd0);
            check("rbp_rvalid", 32'(S_AXI_RVALID), 32'd1);
            @(posedge clk);
            #1;
        end
        S_AXI_ARVALID = 1'b0;
        r_mode = 1;
        repeat (3) @(posedge clk);
        #1;

        S_AXI_AWADDR  = 32'h14;
        S_AXI_WDATA   = 32'hCAFE0001;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_AWVALID = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("split_awready", 32'(S_AXI_AWREADY), 32'd0);
            check("split_wready", 32'(S_AXI_WREADY), 32'd0);
            @(posedge clk);
            #1;
        end
        do_write(32'h14, 32'hCAFE0001, 4'hF);
        check("split_regs", regs_o[5*32 +: 32], 32'hCAFE0001);

        do_both(32'h08, 32'h08, 32'h2, 4'hF);
        check("coll_rdata", S_AXI_RDATA, 32'h1);
        do_read(32'h08);

        b_mode = 2;
        r_mode = 2;
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            logic [31:0] a2;
            int op;
            op = int'($urandom_range(0, 4));
            a  = ($urandom_range(0, 7) == 0) ? $urandom
                 : 32'($urandom_range(0, NR * 4 - 1));
            a2 = 32'($urandom_range(0, NR * 4 - 1));
            if (op <= 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)));
            else if (op <= 3)
                do_read(a);
            else
                do_both(a2, a, $urandom, 4'($urandom_range(0, 15)));
        end
        b_mode = 1;
        r_mode = 1;
        for (int i = 0; i < 100 && (bq.size() != 0 || rq.size() != 0); i++)
            @(posedge clk);
        #1;
        check("drain_b", 32'(bq.size()), 32'd0);
        check("drain_r", 32'(rq.size()), 32'd0);
        check_image("rand_image");

        b_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        do_write(32'h18, 32'h99, 4'hF);
        check("prerst_bvalid", 32'(S_AXI_BVALID), 32'd1);
        rst = 1'b1;
        bq.delete();
        rq.delete();
        for (int k = 0; k < NR; k++) m_reg[k] = '0;
        #1;
        check("midrst_bvalid", 32'(S_AXI_BVALID), 32'd0);
        check_image("midrst_image");
        @(negedge clk);
        rst = 1'b0;
        b_mode = 1;
        @(posedge clk);
        #1;
        do_read(32'h18);
        repeat (5) @(posedge clk);
        #1;
        check("final_r", 32'(rq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_slave_regbank.md
Name: axi_lite_slave_regbank

Overview:
- AXI4-Lite slave register bank; the downstream consumer of the team's single-beat AXI4-Lite master.
- Terminates AW/W/B and AR/R channels against an array of NUM_REGS software-visible registers.
- Register 0 is a read-only status word driven by hardware. Registers 1..NUM_REGS-1 are read/write control registers, exported flat to the surrounding logic.

Parameters:
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width; fixed at 32 (WSTRB is 4 bits)
- NUM_REGS, 16, number of 32-bit registers; power of two, 2..256; IDXW = log2(NUM_REGS)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- S_AXI_AWADDR  in  ADDR_WIDTH  write address
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  write address ready
- S_AXI_WDATA  in  DATA_WIDTH  write data
- S_AXI_WSTRB  in  4  byte enables
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  write data ready
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID  out  1  write response valid
- S_AXI_BREADY  in  1  write response ready
- S_AXI_ARADDR  in  ADDR_WIDTH  read address
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  read address ready
- S_AXI_RDATA  out  DATA_WIDTH  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  read data ready
- status_i  in  DATA_WIDTH  value returned by register 0
- regs_o  out  NUM_REGS*DATA_WIDTH  flat register image; slice k = register k; slice 0 mirrors status_i

Behaviour:
- Reset (async, rst=1):
  - All registers 1..N-1 = 0.
  - BVALID=0, RVALID=0, BRESP=00, RRESP=00, RDATA=0.
- Address decode:
  - idx = addr[IDXW+1:2]; addr[1:0] are ignored.
  - In range iff addr[ADDR_WIDTH-1:IDXW+2] == 0.
- Write channel, joint acceptance:
  - AWREADY = WREADY = AWVALID & WVALID & ~BVALID.
  - Combinational; both handshakes always occur in the same cycle. A lone AWVALID or WVALID is never accepted.
  - This is compatible with masters that wait for both readies together.
- Write commit, at the handshake clock edge T:
  - In range and idx != 0: for each byte b with WSTRB[b]=1, reg[idx][8b+7:8b] <= WDATA byte b; BRESP <= OKAY.
  - Out of range or idx == 0: no register change; BRESP <= SLVERR (2'b10).
  - BVALID <= 1 at T, so it is visible in cycle T+1.
- B hold: BVALID and BRESP hold until BREADY=1, then BVALID <= 0. No new write is accepted while BVALID=1, so at most one write is outstanding.
- WSTRB=0 with an in-range address: no change, BRESP=OKAY.
- Read channel:
  - ARREADY = ~RVALID (independent of ARVALID).
  - At the handshake edge T, RDATA/RRESP/RVALID are registered:
    - idx == 0: RDATA = status_i.
    - other in-range idx: RDATA = reg[idx].
    - out of range: RDATA = 0, RRESP = SLVERR.
  - Read latency is 1 cycle.
  - RVALID, RDATA and RRESP hold stable until RREADY=1. RVALID clears on that edge.
- Simultaneous read and write to the same register on the same edge: the read returns the pre-write value.
- Read and write paths are fully independent and may complete in the same cycle.
- Reset mid-transaction: pending BVALID/RVALID drop immediately; no partial write is visible.
- regs_o: driven directly from the register flops, so a write is visible on regs_o from cycle T+1.

Decomposition:
- Package axi_lite_pkg:
  - axi_resp_t (logic[1:0]).
  - Constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - The master and this slave share the package.
- One sub-module, axi_lite_reg_array:
  - NUM_REGS x 32 storage with byte-strobe write port (we, idx, wdata, wstrb).
  - Asynchronous read port, used by the R-channel register.
  - Flat image output.
- The top level holds the channel handshake logic and address decode.

Test Plan:
- Write then read: AW=0x04, W=0xDEADBEEF, WSTRB=F, BREADY=1 → BVALID the next cycle with BRESP=00, regs_o[63:32]=0xDEADBEEF; read AR=0x04 → RVALID one cycle after the AR handshake, RDATA=0xDEADBEEF, RRESP=00.
- Byte strobes: reg1=0xDEADBEEF, then write 0x11223344 with WSTRB=0101 → read 0xDE22BE44.
- Errors:
  - Write 0x40 (NUM_REGS=16) → SLVERR, no register changes.
  - Write 0x00 → SLVERR, reg0 still reads status_i=0xA5A5A5A5.
  - Read 0x80 → RDATA=0, RRESP=10.
- Backpressure:
  - Hold BREADY=0 for 5 cycles → BVALID/BRESP stable; a second AW/W pair presented meanwhile sees AWREADY=WREADY=0; it is accepted the cycle after BREADY=1.
  - Same check on R: hold RREADY=0, ARREADY=0 throughout.
- Split valids: AWVALID alone for 3 cycles, then WVALID → no handshake until both are high; a single commit.
- Collision and reset:
  - Read and write of reg2 (old 0x1, new 0x2) on the same edge → RDATA=0x1, a later read returns 0x2.
  - Assert rst while BVALID=1 → BVALID=0 immediately, all regs 0.
